// File: rtl/mwsr_wr_arbiter.sv
// mwsr_wr_arbiter
//   Round-robin write arbiter that shares one narrow-write / wide-read FIFO
//   among N_REQ requesters. A grantee owns the FIFO write port for exactly
//   RATIO = R_WIDTH/W_WIDTH beats, so every wide read word comes from a single
//   source. A stalled grantee is padded out with PAD_VALUE after TIMEOUT idle
//   cycles (TIMEOUT = 0 disables padding). One owner record is emitted per
//   completed wide word, one cycle after its last beat is written.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   req_valid     per-requester data valid
//   req_data      requester i data at [i*W_WIDTH +: W_WIDTH]
//   req_ready     per-requester accept (combinational)
//   fifo_wr_en    FIFO write strobe (combinational, never while fifo_full)
//   fifo_wr_data  FIFO write data (combinational)
//   fifo_full     FIFO full
//   owner_valid   1-cycle pulse: a wide word was completed
//   owner_id      requester owning the completed word
//   owner_padded  completed word contains at least one pad beat
//   busy          FSM is not IDLE
//
// Handshake: a requester beat moves when req_valid[i] & req_ready[i] are both
// high at a rising clk edge; req_ready only ever rises for the current grantee
// in BURST and only while the FIFO is not full. A write happens on every cycle
// fifo_wr_en is high.
module mwsr_wr_arbiter #(
  parameter int                  N_REQ     = 4,
  parameter int                  W_WIDTH   = 16,
  parameter int                  R_WIDTH   = 32,
  parameter int                  TIMEOUT   = 8,
  parameter logic [W_WIDTH-1:0]  PAD_VALUE = '0,
  parameter int                  ID_WIDTH  = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*W_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       fifo_wr_en,
  output logic [W_WIDTH-1:0]         fifo_wr_data,
  input  logic                       fifo_full,
  output logic                       owner_valid,
  output logic [ID_WIDTH-1:0]        owner_id,
  output logic                       owner_padded,
  output logic                       busy
);

  localparam int RATIO  = R_WIDTH / W_WIDTH;
  localparam int BEAT_W = $clog2(RATIO) + 1;
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(RATIO - 1);
  // The idle count is compared before it increments, so the PAD transition
  // is taken on the cycle whose increment makes it reach TIMEOUT.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_PAD   = 2'd2
  } state_t;

  // Observable FSM state (state_q) for checkers bound to this block.
  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                padded_q, padded_d;
  logic                owner_valid_q, owner_padded_q;
  logic [ID_WIDTH-1:0] owner_id_q;

  logic                done;
  logic                done_padded;
  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_idx;
  logic [ID_WIDTH-1:0] cand;
  logic [W_WIDTH-1:0]  req_word [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*W_WIDTH +: W_WIDTH];
  end

  // Round-robin pick: walk offsets from N_REQ down to 1 so the candidate
  // nearest to last_grant+1 is the last one written and therefore wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = ID_WIDTH'((int'(last_grant_q) + i) % N_REQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    idle_d       = idle_q;
    padded_d     = padded_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    done         = 1'b0;
    done_padded  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d  = pick_idx;
          beat_d   = '0;
          idle_d   = '0;
          padded_d = 1'b0;
          state_d  = ST_BURST;
        end
      end

      ST_BURST: begin
        req_ready[grant_q] = !fifo_full;
        if (!fifo_full) begin
          if (req_valid[grant_q]) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = req_word[grant_q];
            beat_d       = beat_q + BEAT_W'(1);
            idle_d       = '0;
            done         = (beat_q == BEAT_LAST);
            done_padded  = padded_q;
          end else if (TIMEOUT != 0) begin
            idle_d = idle_q + IDLE_W'(1);
            if (idle_q == IDLE_LAST) begin
              state_d = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        if (!fifo_full) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = PAD_VALUE;
          beat_d       = beat_q + BEAT_W'(1);
          padded_d     = 1'b1;
          done         = (beat_q == BEAT_LAST);
          done_padded  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      state_d      = ST_IDLE;
      last_grant_d = grant_q;
      beat_d       = '0;
      idle_d       = '0;
      padded_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      last_grant_q   <= ID_WIDTH'(N_REQ - 1);
      beat_q         <= '0;
      idle_q         <= '0;
      padded_q       <= 1'b0;
      owner_valid_q  <= 1'b0;
      owner_id_q     <= '0;
      owner_padded_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      beat_q         <= beat_d;
      idle_q         <= idle_d;
      padded_q       <= padded_d;
      owner_valid_q  <= done;
      owner_id_q     <= done ? grant_q : '0;
      owner_padded_q <= done & done_padded;
    end
  end

  assign owner_valid  = owner_valid_q;
  assign owner_id     = owner_id_q;
  assign owner_padded = owner_padded_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
